// File: rtl/counter8_pkg.sv
// counter8_pkg: shared defaults and types for the counter8 slice.
//   COUNTER8_WIDTH      default counter width
//   COUNTER8_RESET_VAL  default value loaded by reset
//   MAX_COUNT           all-ones value of the default-width counter
//   count_t             default-width count type
package counter8_pkg;

  localparam int COUNTER8_WIDTH     = 8;
  localparam int COUNTER8_RESET_VAL = 0;
  localparam int MAX_COUNT          = (1 << COUNTER8_WIDTH) - 1;

  typedef logic [COUNTER8_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter8_incr.sv
// counter8_incr: purely combinational WIDTH-bit +1 incrementer.
// A ripple chain of half adders: the carry into bit 0 is the constant 1,
// so every stage is just an XOR (sum) and an AND (carry).
// Ports:
//   a      in   WIDTH  value to increment
//   sum    out  WIDTH  (a + 1) mod 2^WIDTH
//   carry  out  1      carry-out; high only when a is all-ones
module counter8_incr #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]  = a[i] ^ c[i];
    assign c[i+1]  = a[i] & c[i];
  end

  assign carry = c[WIDTH];

endmodule

// File: rtl/counter8.sv
// counter8: free-running WIDTH-bit binary up-counter, wraps modulo 2^WIDTH.
// No enable or load; counts every clk edge once out of reset.
// Optional feature macro: COUNTER8_WRAP_FLAG_EN adds the registered wrap flag.
// Ports:
//   clk    in   1      sole clock, rising edge
//   reset  in   1      synchronous, active-high; has priority over counting
//   cout   out  WIDTH  registered count (no power-up value before reset)
//   wrap   out  1      (COUNTER8_WRAP_FLAG_EN only) high for the one cycle in
//                      which cout is 0 because it wrapped from all-ones
module counter8
  import counter8_pkg::*;
#(
  parameter int               WIDTH     = COUNTER8_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER8_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cout
`ifdef COUNTER8_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] nxt;
  logic             carry;

  counter8_incr #(.WIDTH(WIDTH)) u_incr (
    .a     (cout),
    .sum   (nxt),
    .carry (carry)
  );

  // Count register: no initializer on purpose, reset defines the start value.
  always_ff @(posedge clk) begin
    if (reset) cout <= RESET_VAL;
    else       cout <= nxt;
  end

`ifdef COUNTER8_WRAP_FLAG_EN
  // Carry-out of the incrementer means this edge takes cout from all-ones
  // to 0, so registering it aligns wrap with the cycle cout reads 0.
  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= carry;
  end
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule

// File: tb/tb_counter8.sv
// tb_counter8: directed self-checking bench for counter8.
// Stimulus changes at phase 10 ns of each 100 ns period (edges at phase 50),
// directed checks also sit at phase 10; a per-edge monitor checks cout
// against an independent model count on every falling edge after reset.
module tb_counter8;

  logic       clk;
  logic       reset;
  logic [7:0] cout;
`ifdef COUNTER8_WRAP_FLAG_EN
  logic       wrap;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  counter8 dut (
    .clk   (clk),
    .reset (reset),
    .cout  (cout)
`ifdef COUNTER8_WRAP_FLAG_EN
    ,
    .wrap  (wrap)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Independent reference: 0 on reset, else +1 mod 256.
  logic [7:0] mdl;
  logic       mdl_wrap;
  logic       armed = 1'b0;

  always @(posedge clk) begin
    mdl      <= reset ? 8'd0 : mdl + 8'd1;
    mdl_wrap <= !reset && (mdl == 8'hFF);
    armed    <= armed | reset;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("mon_cout", 32'(cout), 32'(mdl));
`ifdef COUNTER8_WRAP_FLAG_EN
      chk("mon_wrap", 32'(wrap), 32'(mdl_wrap));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) #100;
  endtask

  task automatic chk_wrap(input string tag, input logic exp);
`ifdef COUNTER8_WRAP_FLAG_EN
    chk(tag, 32'(wrap), 32'(exp));
`endif
  endtask

  initial begin
    reset = 1'b0;
    #100 reset = 1'b1;
    #100 reset = 1'b0;
    #10;                                   // t=210
    chk("rst_cout", 32'(cout), 32'd0);
    chk_wrap("rst_wrap", 1'b0);
    step(1); chk("first_cnt", 32'(cout), 32'd1);
    step(1); chk("second_cnt", 32'(cout), 32'd2);

    // Free-run 256 edges from reset.
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("rerst_cout", 32'(cout), 32'd0);
    step(255);
    chk("cnt_255", 32'(cout), 32'd255);
    chk_wrap("wrap_pre", 1'b0);
    step(1);
    chk("cnt_wrap0", 32'(cout), 32'd0);
    chk_wrap("wrap_set", 1'b1);
    step(1);
    chk("cnt_after_wrap", 32'(cout), 32'd1);
    chk_wrap("wrap_clr", 1'b0);

    // One-edge reset while cout = 0x7A.
    step(8'h79);
    chk("cnt_7a", 32'(cout), 32'h7A);
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("mid_rst", 32'(cout), 32'd0);
    chk_wrap("mid_rst_wrap", 1'b0);
    step(1); chk("mid_rst_p1", 32'(cout), 32'd1);
    step(1); chk("mid_rst_p2", 32'(cout), 32'd2);

    // Hold reset for 5 edges.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_rst", 32'(cout), 32'd0);
      chk_wrap("hold_wrap", 1'b0);
    end
    reset = 1'b0;
    step(1); chk("hold_rel", 32'(cout), 32'd1);

    // Reset pulses strictly between edges (phase 60..80) are ignored.
    for (int i = 0; i < 3; i++) begin
      #50 reset = 1'b1;
      #20 reset = 1'b0;
      #30;
      chk("glitch", 32'(cout), 32'(2 + i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
